// File: rtl/alu_seq_ctrl_if.sv
// Signal bundle between alu_seq_ctrl and its neighbours: the instruction
// source, the combinational 8-bit ALU, and the result consumer.
interface alu_seq_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_ld;
    logic [2:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic       in_imm_en;
    logic [7:0] in_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_y;
    logic       alu_carry;
    logic       alu_zero;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;
    logic       out_zero;

    modport slave (
        input  in_valid, in_ld, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        input  alu_y, alu_carry, alu_zero, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_data, out_carry, out_zero
    );

    modport master (
        output in_valid, in_ld, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        output alu_y, alu_carry, alu_zero, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_data, out_carry, out_zero
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Issue/writeback controller for the 8-bit combinational ALU: one instruction
// in flight, 4x8 register file, results held until the consumer takes them.
module alu_seq_ctrl #(
    parameter int NREG = 4,
    parameter int DW   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;

    logic [2:0]      r_op;
    logic [1:0]      r_rd;
    logic [1:0]      r_rs1;
    logic [1:0]      r_rs2;
    logic            r_imm_en;
    logic [DW-1:0]   r_imm;

    logic [DW-1:0]   r_rf [NREG];
    logic            r_in_ready;
    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;
    logic            r_out_carry;
    logic            r_out_zero;

    logic [DW-1:0]   w_alu_a;
    logic [DW-1:0]   w_alu_b;
    logic [2:0]      w_alu_op;

    assign w_accept = r_in_ready & bus.in_valid;

    // Next-state decode; a load skips EXEC because it never touches the ALU.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = bus.in_ld ? RESP : EXEC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == RESP);
        end
    end

    // Instruction register, captured on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 3'd0;
            r_rd     <= 2'd0;
            r_rs1    <= 2'd0;
            r_rs2    <= 2'd0;
            r_imm_en <= 1'b0;
            r_imm    <= '0;
        end else if (w_accept) begin
            r_op     <= bus.in_op;
            r_rd     <= bus.in_rd;
            r_rs1    <= bus.in_rs1;
            r_rs2    <= bus.in_rs2;
            r_imm_en <= bus.in_imm_en;
            r_imm    <= bus.in_imm;
        end
    end

    // Writeback: rf and result latch update together, so a result held in
    // RESP always matches the register it was written to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
            r_out_data  <= '0;
            r_out_carry <= 1'b0;
            r_out_zero  <= 1'b0;
        end else if (w_accept && bus.in_ld) begin
            r_rf[bus.in_rd] <= bus.in_imm;
            r_out_data      <= bus.in_imm;
            r_out_carry     <= 1'b0;
            r_out_zero      <= (bus.in_imm == 8'h00);
        end else if (r_state == EXEC) begin
            r_rf[r_rd]  <= bus.alu_y;
            r_out_data  <= bus.alu_y;
            r_out_carry <= bus.alu_carry;
            r_out_zero  <= bus.alu_zero;
        end
    end

    // ALU operands are live only in EXEC and forced to zero otherwise.
    always_comb begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alu_op = 3'd0;
        if (r_state == EXEC) begin
            w_alu_a  = r_rf[r_rs1];
            w_alu_b  = r_imm_en ? r_imm : r_rf[r_rs2];
            w_alu_op = r_op;
        end else begin
            w_alu_a  = '0;
            w_alu_b  = '0;
            w_alu_op = 3'd0;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_carry = r_out_carry;
    assign bus.out_zero  = r_out_zero;
    assign bus.alu_a     = w_alu_a;
    assign bus.alu_b     = w_alu_b;
    assign bus.alu_op    = w_alu_op;

endmodule
